// File: rtl/servo.sv
// servo: one RC-servo channel; slews position toward a clamped target and drives a 50 Hz PWM pulse
// Ports: i_clk system clock, i_rst async active-high reset, i_slk slew strobe (rising edge = one step),
//        i_count shared 28-bit frame counter, i_desired 20-bit target above MIN_PULSE,
//        o_pwm registered servo pulse, o_flag registered position==target
module servo #(
  parameter int MIN_PULSE = 50000,
  parameter int MAX_POS   = 200000,
  parameter int STEP      = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_slk,
  input  logic [27:0] i_count,
  input  logic [19:0] i_desired,
  output logic        o_pwm,
  output logic        o_flag
);
  localparam logic [19:0] LP_MAX  = 20'(MAX_POS);
  localparam logic [19:0] LP_STEP = 20'(STEP);
  localparam logic [27:0] LP_MIN  = 28'(MIN_PULSE);
  logic [19:0] r_pos, w_tgt, w_up, w_dn, w_next;
  logic        r_slk_d, w_edge;
  // Distance is compared against STEP so the last step lands exactly on the target
  // and neither direction can overshoot or wrap.
  always_comb begin
    w_tgt  = (i_desired > LP_MAX) ? LP_MAX : i_desired;
    w_edge = i_slk & ~r_slk_d;
    w_up   = (w_tgt - r_pos > LP_STEP) ? r_pos + LP_STEP : w_tgt;
    w_dn   = (r_pos - w_tgt > LP_STEP) ? r_pos - LP_STEP : w_tgt;
    w_next = !w_edge ? r_pos : (r_pos < w_tgt) ? w_up : (r_pos > w_tgt) ? w_dn : r_pos;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      r_pos   <= '0;
      r_slk_d <= 1'b0;
      o_pwm   <= 1'b0;
      o_flag  <= 1'b0;
    end else begin
      r_slk_d <= i_slk;
      r_pos   <= w_next;
      o_pwm   <= i_count < LP_MIN + {8'd0, r_pos};
      o_flag  <= r_pos == w_tgt;
    end
endmodule

// File: tb/tb_servo.sv
module tb_servo;
  logic        clk = 1'b0;
  logic        rst;
  logic        slk;
  logic [27:0] count;
  logic [19:0] desired;
  logic        pwm, flag, pwm_f, flag_f;
  int          checks = 0;
  int          errors = 0;
  int          m_pos[2];
  logic        m_slk_d;
  logic [3:0]  sb[$];

  always #5 clk = ~clk;

  servo u_dut (
    .i_clk(clk), .i_rst(rst), .i_slk(slk), .i_count(count), .i_desired(desired),
    .o_pwm(pwm), .o_flag(flag)
  );

  servo #(.STEP(4096)) u_fast (
    .i_clk(clk), .i_rst(rst), .i_slk(slk), .i_count(count), .i_desired(desired),
    .o_pwm(pwm_f), .o_flag(flag_f)
  );

  task automatic step(input logic s, input logic [27:0] c, input logic [19:0] d);
    int t;
    int st;
    logic [3:0] e;
    logic [3:0] got;
    slk = s;
    count = c;
    desired = d;
    t = (d > 200000) ? 200000 : int'(d);
    for (int k = 0; k < 2; k++) begin
      e[2*k+1] = !rst && (c < 50000 + m_pos[k]);
      e[2*k]   = !rst && (m_pos[k] == t);
      st = k ? 4096 : 1;
      if (rst) m_pos[k] = 0;
      else if (s && !m_slk_d) begin
        if (m_pos[k] < t) m_pos[k] = (t - m_pos[k] <= st) ? t : m_pos[k] + st;
        else if (m_pos[k] > t) m_pos[k] = (m_pos[k] - t <= st) ? t : m_pos[k] - st;
      end
    end
    m_slk_d = rst ? 1'b0 : s;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = {pwm_f, flag_f, pwm, flag};
    e = sb.pop_front();
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t count=%0d desired=%0d got {pwm_f,flag_f,pwm,flag}=%b want %b",
               $time, c, d, got, e);
    end
  endtask

  task automatic edges(input int n, input int half, input logic [19:0] d);
    logic [27:0] r;
    repeat (n) begin
      repeat (half) begin r = 28'($urandom_range(0, 260000)); step(1'b0, r, d); end
      repeat (half) begin r = 28'($urandom_range(0, 260000)); step(1'b1, r, d); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(logic'(i % 2 == 0), 28'd0, 20'd5);
      checks++;
      if (pwm !== 1'b0 || flag !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold got pwm=%b flag=%b want 0 0", pwm, flag);
      end
    end
    step(1'b0, 28'd0, 20'd5);
    rst = 1'b0;
    edges(4, 2, 20'd5);
    checks++;
    if (flag !== 1'b0) begin errors++; $display("FAIL reset_flag_pos4 got %b want 0", flag); end
    edges(1, 2, 20'd5);
    step(1'b1, 28'd50004, 20'd5);
    checks++;
    if (pwm !== 1'b1) begin errors++; $display("FAIL reset_pos5_hi got %b want 1", pwm); end
    step(1'b1, 28'd50005, 20'd5);
    checks++;
    if (pwm !== 1'b0 || flag !== 1'b1) begin
      errors++;
      $display("FAIL reset_pos5_lo got pwm=%b flag=%b want 0 1", pwm, flag);
    end
  endtask

  task automatic test_zero;
    int cs[6] = '{0, 1, 49999, 50000, 50001, 1999999};
    rst = 1'b1;
    step(1'b0, 28'd0, 20'd0);
    rst = 1'b0;
    step(1'b0, 28'd0, 20'd0);
    checks++;
    if (flag !== 1'b1) begin errors++; $display("FAIL zero_flag got %b want 1", flag); end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 28'(cs[i]), 20'd0);
      checks++;
      if (pwm !== logic'(i < 3)) begin
        errors++;
        $display("FAIL zero_pwm count=%0d got %b want %b", cs[i], pwm, logic'(i < 3));
      end
    end
  endtask

  task automatic test_ramp_up;
    edges(9, 4, 20'd10);
    checks++;
    if (flag !== 1'b0) begin errors++; $display("FAIL ramp_flag_edge9 got %b want 0", flag); end
    edges(1, 4, 20'd10);
    step(1'b1, 28'd50009, 20'd10);
    checks++;
    if (pwm !== 1'b1) begin errors++; $display("FAIL ramp_pos10_hi got %b want 1", pwm); end
    step(1'b1, 28'd50010, 20'd10);
    checks++;
    if (pwm !== 1'b0 || flag !== 1'b1) begin
      errors++;
      $display("FAIL ramp_pos10_lo got pwm=%b flag=%b want 0 1", pwm, flag);
    end
  endtask

  task automatic test_retarget;
    step(1'b1, 28'd0, 20'd7);
    checks++;
    if (flag !== 1'b0) begin errors++; $display("FAIL retarget_flag_fall got %b want 0", flag); end
    for (int p = 9; p >= 7; p--) begin
      edges(1, 4, 20'd7);
      step(1'b1, 28'(50000 + p - 1), 20'd7);
      checks++;
      if (pwm !== 1'b1) begin errors++; $display("FAIL retarget_hi pos=%0d got %b want 1", p, pwm); end
      step(1'b1, 28'(50000 + p), 20'd7);
      checks++;
      if (pwm !== 1'b0) begin errors++; $display("FAIL retarget_lo pos=%0d got %b want 0", p, pwm); end
    end
    checks++;
    if (flag !== 1'b1) begin errors++; $display("FAIL retarget_flag_rise got %b want 1", flag); end
  endtask

  task automatic test_clamp;
    edges(60, 1, 20'd300000);
    step(1'b1, 28'd249999, 20'd300000);
    checks++;
    if (pwm_f !== 1'b1 || flag_f !== 1'b1) begin
      errors++;
      $display("FAIL clamp_hi got pwm=%b flag=%b want 1 1", pwm_f, flag_f);
    end
    step(1'b1, 28'd250000, 20'd300000);
    checks++;
    if (pwm_f !== 1'b0) begin errors++; $display("FAIL clamp_lo got %b want 0", pwm_f); end
    checks++;
    if (flag !== 1'b0) begin errors++; $display("FAIL clamp_slow_flag got %b want 0", flag); end
  endtask

  task automatic test_async_reset;
    rst = 1'b1;
    step(1'b0, 28'd0, 20'd10);
    rst = 1'b0;
    edges(4, 2, 20'd10);
    step(1'b1, 28'd0, 20'd10);
    checks++;
    if (pwm !== 1'b1 || flag_f !== 1'b1) begin
      errors++;
      $display("FAIL async_pre got pwm=%b flag_f=%b want 1 1", pwm, flag_f);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (pwm !== 1'b0 || flag !== 1'b0 || flag_f !== 1'b0 || pwm_f !== 1'b0) begin
      errors++;
      $display("FAIL async_clear got pwm=%b flag=%b pwm_f=%b flag_f=%b want 0 0 0 0", pwm, flag, pwm_f, flag_f);
    end
    #1 rst = 1'b0;
    m_pos[0] = 0;
    m_pos[1] = 0;
    m_slk_d = 1'b0;
    step(1'b1, 28'd50000, 20'd10);
    step(1'b1, 28'd50000, 20'd10);
    checks++;
    if (pwm !== 1'b1) begin errors++; $display("FAIL async_restart got %b want 1", pwm); end
    step(1'b1, 28'd50001, 20'd10);
    checks++;
    if (pwm !== 1'b0) begin errors++; $display("FAIL async_one_step got %b want 0", pwm); end
  endtask

  initial begin
    rst = 1'b1;
    slk = 1'b0;
    count = '0;
    desired = '0;
    m_pos[0] = 0;
    m_pos[1] = 0;
    m_slk_d = 1'b0;
    test_reset;
    test_zero;
    test_ramp_up;
    test_retarget;
    test_clamp;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
